mult_rsp_buf: RTL and testbench

- Flow-control wrapper around the fixed-latency, non-stallable 64-bit multiplier pipeline.
- Accepts operand pairs from a requester with valid/ready handshake and issues them to the multiplier.
- Captures every multiplier result in a result FIFO and presents results downstream with valid/ready.
- Credit counting guarantees the FIFO can never overflow, so downstream backpressure never loses a result even though the multiplier cannot stall.

---
 rtl/mult_rsp_buf_if.sv | 30 +++
 rtl/mult_rsp_buf.sv | 83 ++++++++
 tb/tb_mult_rsp_buf.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_rsp_buf_if.sv
// Signal bundle around mult_rsp_buf: requester, multiplier issue/return and result consumer.
// The slave modport is the block's view; the master modport is its environment's view.
interface mult_rsp_buf_if #(
  parameter int CW = 6
);
  logic          i_req_vld;
  logic [63:0]   i_req_a;
  logic [63:0]   i_req_b;
  logic          o_req_rdy;
  logic [63:0]   o_mul_a;
  logic [63:0]   o_mul_b;
  logic          o_mul_vld;
  logic [63:0]   i_mul_res;
  logic          i_mul_vld;
  logic [63:0]   o_res;
  logic          o_vld;
  logic          i_rdy;
  logic [CW-1:0] o_cnt;
  logic          o_ovf;

  modport slave (
    input  i_req_vld, i_req_a, i_req_b, i_mul_res, i_mul_vld, i_rdy,
    output o_req_rdy, o_mul_a, o_mul_b, o_mul_vld, o_res, o_vld, o_cnt, o_ovf
  );

  modport master (
    output i_req_vld, i_req_a, i_req_b, i_mul_res, i_mul_vld, i_rdy,
    input  o_req_rdy, o_mul_a, o_mul_b, o_mul_vld, o_res, o_vld, o_cnt, o_ovf
  );
endinterface

// File: rtl/mult_rsp_buf.sv
// Credit-based flow-control wrapper for a fixed-latency, non-stallable 64-bit multiplier.
// Every issued operand pair reserves a result FIFO slot, so downstream backpressure never drops a product.
module mult_rsp_buf #(
  parameter int DEPTH = 32,
  parameter int CW    = 6
) (
  input logic           ck,
  input logic           i_rst,
  mult_rsp_buf_if.slave bus
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CW   = CW'(1);
  localparam logic [AW-1:0] ONE_AW   = AW'(1);

  logic [CW-1:0] credits;
  logic [CW-1:0] credits_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [63:0]   mem [DEPTH];
  logic          ovf;
  logic          issue;
  logic          pop;
  logic          full;
  logic          wr_en;
  logic          drop;

  assign bus.o_req_rdy = (credits != '0);
  assign issue         = bus.i_req_vld & bus.o_req_rdy;
  assign bus.o_vld     = (cnt != '0);
  assign pop           = bus.o_vld & bus.i_rdy;
  assign full          = (cnt == FULL_CNT);

  // A full FIFO still accepts a product when the head leaves on the same edge.
  assign wr_en = bus.i_mul_vld & (~full | pop);
  assign drop  = bus.i_mul_vld & full & ~pop;

  assign bus.o_res = mem[rd_ptr];
  assign bus.o_cnt = cnt;
  assign bus.o_ovf = ovf;

  always_comb begin
    // NOTE: defaults first, so every path assigns both outputs and no latch is inferred.
    credits_nxt = credits;
    cnt_nxt     = cnt;
    if (issue && !pop)      credits_nxt = credits - ONE_CW;
    else if (pop && !issue) credits_nxt = credits + ONE_CW;
    if (wr_en && !pop)      cnt_nxt = cnt + ONE_CW;
    else if (pop && !wr_en) cnt_nxt = cnt - ONE_CW;
  end

  always_ff @(posedge ck) begin
    // NOTE: non-blocking assignments, so every register sees pre-edge values regardless of statement order.
    if (i_rst) begin
      credits       <= FULL_CNT;
      cnt           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      ovf           <= 1'b0;
      bus.o_mul_vld <= 1'b0;
      bus.o_mul_a   <= '0;
      bus.o_mul_b   <= '0;
    end else begin
      credits       <= credits_nxt;
      cnt           <= cnt_nxt;
      bus.o_mul_vld <= issue;
      if (wr_en) wr_ptr <= wr_ptr + ONE_AW;
      if (pop)   rd_ptr <= rd_ptr + ONE_AW;
      if (drop)  ovf    <= 1'b1;
      if (issue) begin
        bus.o_mul_a <= bus.i_req_a;
        bus.o_mul_b <= bus.i_req_b;
      end
    end
  end

  // NOTE: storage has no reset; o_vld qualifies o_res, so stale entries are never observed.
  always_ff @(posedge ck) begin
    if (wr_en) mem[wr_ptr] <= bus.i_mul_res;
  end
endmodule

// File: tb/tb_mult_rsp_buf.sv
// Self-checking bench for mult_rsp_buf with an 18-stage multiplier model and a
// transaction-level scoreboard built from issue/pop handshakes.
module tb_mult_rsp_buf;
  localparam int DEPTH = 32;
  localparam int CW    = 6;
  localparam int LAT   = 18;

  logic ck    = 1'b0;
  logic i_rst = 1'b1;
  always #5 ck = ~ck;

  mult_rsp_buf_if #(.CW(CW)) bus ();
  mult_rsp_buf #(.DEPTH(DEPTH), .CW(CW)) dut (.ck(ck), .i_rst(i_rst), .bus(bus));

  // Multiplier model: 18 stages of operands and valid; the valid pipe clears on reset.
  logic [LAT-1:0] pv;
  logic [63:0]    pa [LAT];
  logic [63:0]    pb [LAT];
  logic           force_wr  = 1'b0;
  logic [63:0]    force_val = '0;

  always @(posedge ck) begin
    if (i_rst) pv <= '0;
    else       pv <= {pv[LAT-2:0], bus.o_mul_vld};
    pa[0] <= bus.o_mul_a;
    pb[0] <= bus.o_mul_b;
    for (int k = 1; k < LAT; k++) begin
      pa[k] <= pa[k-1];
      pb[k] <= pb[k-1];
    end
  end

  assign bus.i_mul_vld = force_wr | pv[LAT-1];
  assign bus.i_mul_res = force_wr ? force_val : pa[LAT-1] * pb[LAT-1];

  // Reference model: expected products in issue order, observed results in pop order.
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          n_iss   = 0;
  int          n_pop   = 0;
  int          n_wr    = 0;
  logic [63:0] exp_q [$];
  logic [63:0] got_q [$];
  int          pop_cyc_q [$];

  always @(posedge ck) begin
    cyc++;
    if (i_rst) begin
      n_iss = 0;
      n_pop = 0;
      n_wr  = 0;
      exp_q.delete();
      got_q.delete();
      pop_cyc_q.delete();
    end else begin
      if (bus.i_req_vld && bus.o_req_rdy) begin
        exp_q.push_back(bus.i_req_a * bus.i_req_b);
        n_iss++;
      end
      if (bus.o_vld && bus.i_rdy) begin
        got_q.push_back(bus.o_res);
        pop_cyc_q.push_back(cyc);
        n_pop++;
      end
      if (bus.i_mul_vld) n_wr++;
    end
  end

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    pop_cyc_q.delete();
  endtask

  task automatic fill_full(input int cycles);
    bus.i_rdy = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge ck);
      bus.i_req_vld = 1'b1;
      bus.i_req_a   = {$urandom, $urandom};
      bus.i_req_b   = {$urandom, $urandom};
    end
    @(negedge ck);
    bus.i_req_vld = 1'b0;
    repeat (LAT + 7) @(negedge ck);
  endtask

  task automatic wait_got(input int n, input int budget, input string name);
    for (int w = 0; w < budget && got_q.size() < n; w++) @(negedge ck);
    n_tests++;
    if (got_q.size() < n) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d results, required %0d", name, got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(negedge ck);
    i_rst = 1'b0;
    n_tests++; if (bus.o_vld !== 1'b0)     begin n_fail++; $display("FAIL rst_o_vld: got %b required 0", bus.o_vld); end
    n_tests++; if (bus.o_mul_vld !== 1'b0) begin n_fail++; $display("FAIL rst_o_mul_vld: got %b required 0", bus.o_mul_vld); end
    n_tests++; if (bus.o_ovf !== 1'b0)     begin n_fail++; $display("FAIL rst_o_ovf: got %b required 0", bus.o_ovf); end
    n_tests++; if (bus.o_cnt !== '0)       begin n_fail++; $display("FAIL rst_o_cnt: got %0d required 0", bus.o_cnt); end
    n_tests++; if (bus.o_mul_a !== '0)     begin n_fail++; $display("FAIL rst_o_mul_a: got %0h required 0", bus.o_mul_a); end
    n_tests++; if (bus.o_mul_b !== '0)     begin n_fail++; $display("FAIL rst_o_mul_b: got %0h required 0", bus.o_mul_b); end
    @(negedge ck);
    n_tests++; if (bus.o_req_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_o_req_rdy: got %b required 1", bus.o_req_rdy); end
  endtask

  task automatic test_single();
    int          first_k = -1;
    int          hi_cnt  = 0;
    logic [63:0] res_seen = '0;
    clear_sb();
    bus.i_rdy     = 1'b1;
    bus.i_req_vld = 1'b1;
    bus.i_req_a   = 64'd3;
    bus.i_req_b   = 64'd5;
    @(negedge ck);
    bus.i_req_vld = 1'b0;
    n_tests++; if (bus.o_mul_vld !== 1'b1) begin n_fail++; $display("FAIL single_mul_vld: got %b required 1", bus.o_mul_vld); end
    n_tests++; if (bus.o_mul_a !== 64'd3)  begin n_fail++; $display("FAIL single_mul_a: got %0d required 3", bus.o_mul_a); end
    n_tests++; if (bus.o_mul_b !== 64'd5)  begin n_fail++; $display("FAIL single_mul_b: got %0d required 5", bus.o_mul_b); end
    for (int k = 1; k <= 24; k++) begin
      @(negedge ck);
      if (k == 1) begin
        n_tests++;
        if (bus.o_mul_vld !== 1'b0) begin n_fail++; $display("FAIL single_mul_vld_pulse: got %b required 0", bus.o_mul_vld); end
      end
      if (bus.o_vld === 1'b1) begin
        if (first_k < 0) begin
          first_k  = k;
          res_seen = bus.o_res;
        end
        hi_cnt++;
      end
    end
    // Issue edge t is k=0; the result is first visible after edge t+19 (sampled at t+20).
    n_tests++; if (first_k != 19)      begin n_fail++; $display("FAIL single_latency: got %0d required 19", first_k); end
    n_tests++; if (hi_cnt != 1)        begin n_fail++; $display("FAIL single_vld_cycles: got %0d required 1", hi_cnt); end
    n_tests++; if (res_seen !== 64'd15) begin n_fail++; $display("FAIL single_res: got %0d required 15", res_seen); end
  endtask

  task automatic test_streaming();
    int drops = 0;
    clear_sb();
    bus.i_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge ck);
      if (bus.o_req_rdy !== 1'b1) drops++;
      bus.i_req_vld = 1'b1;
      bus.i_req_a   = 64'(i);
      bus.i_req_b   = 64'(i + 1);
    end
    @(negedge ck);
    bus.i_req_vld = 1'b0;
    wait_got(100, 200, "stream");
    n_tests++; if (drops != 0) begin n_fail++; $display("FAIL stream_rdy_drops: got %0d required 0", drops); end
    n_tests++; if (got_q.size() != 100) begin n_fail++; $display("FAIL stream_count: got %0d required 100", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 100; i++) begin
      n_tests++;
      if (got_q[i] !== 64'(i) * 64'(i + 1)) begin
        n_fail++;
        $display("FAIL stream_res[%0d]: got %0d required %0d", i, got_q[i], 64'(i) * 64'(i + 1));
      end
    end
    if (pop_cyc_q.size() == 100) begin
      n_tests++;
      if (pop_cyc_q[99] - pop_cyc_q[0] != 99) begin
        n_fail++;
        $display("FAIL stream_back_to_back: got span %0d required 99", pop_cyc_q[99] - pop_cyc_q[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int iss0;
    clear_sb();
    iss0 = n_iss;
    fill_full(60);
    n_tests++; if (n_iss - iss0 != DEPTH)  begin n_fail++; $display("FAIL bp_issues: got %0d required %0d", n_iss - iss0, DEPTH); end
    n_tests++; if (bus.o_req_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_req_rdy: got %b required 0", bus.o_req_rdy); end
    n_tests++; if (bus.o_cnt !== CW'(DEPTH)) begin n_fail++; $display("FAIL bp_cnt: got %0d required %0d", bus.o_cnt, DEPTH); end
    n_tests++; if (bus.o_ovf !== 1'b0)     begin n_fail++; $display("FAIL bp_ovf: got %b required 0", bus.o_ovf); end
    bus.i_rdy = 1'b1;
    @(negedge ck);
    n_tests++; if (bus.o_req_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_rdy_after_pop: got %b required 1", bus.o_req_rdy); end
    wait_got(DEPTH, 100, "bp_drain");
    n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_drain_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_order[%0d]: got %0h required %0h", i, got_q[i], exp_q[i]); end
    end
    n_tests++; if (bus.o_cnt !== '0) begin n_fail++; $display("FAIL bp_cnt_empty: got %0d required 0", bus.o_cnt); end
  endtask

  task automatic test_credit_boundary();
    int iss0;
    int pop0;
    clear_sb();
    fill_full(40);
    n_tests++; if (bus.o_req_rdy !== 1'b0) begin n_fail++; $display("FAIL cb_pre_rdy: got %b required 0", bus.o_req_rdy); end
    iss0 = n_iss;
    pop0 = n_pop;
    bus.i_rdy     = 1'b1;
    bus.i_req_vld = 1'b1;
    bus.i_req_a   = {$urandom, $urandom};
    bus.i_req_b   = {$urandom, $urandom};
    @(negedge ck);
    n_tests++; if (n_iss != iss0)          begin n_fail++; $display("FAIL cb_no_issue: got %0d issues required 0", n_iss - iss0); end
    n_tests++; if (n_pop != pop0 + 1)      begin n_fail++; $display("FAIL cb_pop: got %0d pops required 1", n_pop - pop0); end
    n_tests++; if (bus.o_req_rdy !== 1'b1) begin n_fail++; $display("FAIL cb_rdy_rise: got %b required 1", bus.o_req_rdy); end
    bus.i_rdy = 1'b0;
    @(negedge ck);
    bus.i_req_vld = 1'b0;
    n_tests++; if (n_iss != iss0 + 1)      begin n_fail++; $display("FAIL cb_issue_next: got %0d issues required 1", n_iss - iss0); end
    n_tests++; if (bus.o_req_rdy !== 1'b0) begin n_fail++; $display("FAIL cb_credits_end: got rdy %b required 0", bus.o_req_rdy); end
    bus.i_rdy = 1'b1;
    wait_got(DEPTH + 1, 120, "cb_drain");
    n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL cb_drain_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL cb_order[%0d]: got %0h required %0h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    clear_sb();
    for (int c = 0; c < 400; c++) begin
      @(negedge ck);
      // Outstanding = issued but not yet popped; free slots are what remains of DEPTH.
      n_tests++;
      if (bus.o_req_rdy !== ((n_iss - n_pop) < DEPTH)) begin
        n_fail++; $display("FAIL rand_req_rdy@%0d: got %b required %b", c, bus.o_req_rdy, (n_iss - n_pop) < DEPTH);
      end
      n_tests++;
      if (bus.o_cnt !== CW'(n_wr - n_pop)) begin
        n_fail++; $display("FAIL rand_cnt@%0d: got %0d required %0d", c, bus.o_cnt, n_wr - n_pop);
      end
      n_tests++;
      if (bus.o_vld !== ((n_wr - n_pop) > 0)) begin
        n_fail++; $display("FAIL rand_vld@%0d: got %b required %b", c, bus.o_vld, (n_wr - n_pop) > 0);
      end
      bus.i_req_vld = ($urandom_range(3) != 0);
      bus.i_req_a   = {$urandom, $urandom};
      bus.i_req_b   = {$urandom, $urandom};
      bus.i_rdy     = ($urandom_range(2) != 0);
    end
    @(negedge ck);
    bus.i_req_vld = 1'b0;
    bus.i_rdy     = 1'b1;
    @(negedge ck);
    wait_got(exp_q.size(), 200, "rand_drain");
    n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_order[%0d]: got %0h required %0h", i, got_q[i], exp_q[i]); end
    end
    n_tests++; if (bus.o_ovf !== 1'b0) begin n_fail++; $display("FAIL rand_ovf: got %b required 0", bus.o_ovf); end
  endtask

  task automatic test_overflow_reset();
    int vld_seen = 0;
    clear_sb();
    fill_full(40);
    n_tests++; if (bus.o_cnt !== CW'(DEPTH)) begin n_fail++; $display("FAIL ovf_pre_cnt: got %0d required %0d", bus.o_cnt, DEPTH); end
    force_val = {$urandom, $urandom};
    force_wr  = 1'b1;
    @(negedge ck);
    force_wr = 1'b0;
    n_tests++; if (bus.o_ovf !== 1'b1)       begin n_fail++; $display("FAIL ovf_flag: got %b required 1", bus.o_ovf); end
    n_tests++; if (bus.o_cnt !== CW'(DEPTH)) begin n_fail++; $display("FAIL ovf_cnt: got %0d required %0d", bus.o_cnt, DEPTH); end
    if (exp_q.size() > 0) begin
      n_tests++;
      if (bus.o_res !== exp_q[0]) begin n_fail++; $display("FAIL ovf_head: got %0h required %0h", bus.o_res, exp_q[0]); end
    end
    bus.i_rdy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge ck);
      bus.i_req_vld = 1'b1;
      bus.i_req_a   = {$urandom, $urandom};
      bus.i_req_b   = {$urandom, $urandom};
    end
    n_tests++; if (bus.o_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b required 1", bus.o_ovf); end
    i_rst         = 1'b1;
    bus.i_req_vld = 1'b0;
    @(negedge ck);
    i_rst = 1'b0;
    n_tests++; if (bus.o_vld !== 1'b0)     begin n_fail++; $display("FAIL mrst_o_vld: got %b required 0", bus.o_vld); end
    n_tests++; if (bus.o_mul_vld !== 1'b0) begin n_fail++; $display("FAIL mrst_o_mul_vld: got %b required 0", bus.o_mul_vld); end
    n_tests++; if (bus.o_ovf !== 1'b0)     begin n_fail++; $display("FAIL mrst_o_ovf: got %b required 0", bus.o_ovf); end
    n_tests++; if (bus.o_cnt !== '0)       begin n_fail++; $display("FAIL mrst_o_cnt: got %0d required 0", bus.o_cnt); end
    n_tests++; if (bus.o_req_rdy !== 1'b1) begin n_fail++; $display("FAIL mrst_o_req_rdy: got %b required 1", bus.o_req_rdy); end
    n_tests++; if (bus.o_mul_a !== '0)     begin n_fail++; $display("FAIL mrst_o_mul_a: got %0h required 0", bus.o_mul_a); end
    for (int c = 0; c < LAT + 7; c++) begin
      @(negedge ck);
      if (bus.o_vld === 1'b1) vld_seen++;
    end
    n_tests++; if (vld_seen != 0) begin n_fail++; $display("FAIL mrst_inflight_discard: got %0d valid cycles required 0", vld_seen); end
  endtask

  initial begin
    bus.i_req_vld = 1'b0;
    bus.i_req_a   = '0;
    bus.i_req_b   = '0;
    bus.i_rdy     = 1'b0;
    test_reset();
    test_single();
    test_streaming();
    test_backpressure();
    test_credit_boundary();
    test_random();
    test_overflow_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
